// File: rtl/dot_arbiter_if.sv
// dot_arbiter_if: request pair A/B handshakes plus the result handshake.
// master drives requests and res_ready; slave is the arbiter side.
interface dot_arbiter_if #(
  parameter int WIDTH = 6
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             res_valid;
  logic             res_id;
  logic [CW-1:0]    res_data;
  logic             res_ready;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_id, res_data
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_id, res_data
  );
endinterface

// File: rtl/dot_arbiter.sv
// dot_arbiter: round-robin share of one bit-serial popcount(A&B) engine.
// Ports: clock, reset (async high), bus (slave modport), busy.
// DOT_ARBITER_EARLY_EXIT_EN: stop shifting once either operand is empty.
module dot_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic          clock,
  input  logic          reset,
  dot_arbiter_if.slave  bus,
  output logic          busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sa_nx;
  logic [WIDTH-1:0] sb_nx;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    acc_nx;
  logic [CW-1:0]    count;
  logic             last_grant;
  logic             gnt_id;
  logic             pick0;
  logic             pick1;
  logic             take;
  logic             last_cyc;
  logic             done_ack;

  // Tie goes to the requester that did not win last time.
  always_comb begin
    pick0 = bus.req0_valid & (~bus.req1_valid | last_grant);
    pick1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    bus.req0_ready = (state == IDLE) & ~reset & pick0;
    bus.req1_ready = (state == IDLE) & ~reset & pick1;
    take = (bus.req0_valid & bus.req0_ready)
         | (bus.req1_valid & bus.req1_ready);
    sa_nx  = sa >> 1;
    sb_nx  = sb >> 1;
    acc_nx = acc + CW'(sa[0] & sb[0]);
`ifdef DOT_ARBITER_EARLY_EXIT_EN
    // Remaining bits cannot add anything once one side is all zero.
    last_cyc = (count == CW'(WIDTH - 1))
             | (sa_nx == '0) | (sb_nx == '0);
`else
    last_cyc = (count == CW'(WIDTH - 1));
`endif
    done_ack = bus.res_valid & bus.res_ready;
    busy     = (state != IDLE);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = SHIFT;
      SHIFT:   if (last_cyc) state_nx = DONE;
      DONE:    if (done_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sa            <= '0;
      sb            <= '0;
      acc           <= '0;
      count         <= '0;
      last_grant    <= 1'b1;
      gnt_id        <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= 1'b0;
      bus.res_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            sa     <= bus.req1_ready ? bus.req1_a : bus.req0_a;
            sb     <= bus.req1_ready ? bus.req1_b : bus.req0_b;
            acc    <= '0;
            count  <= '0;
            gnt_id <= bus.req1_ready;
          end
        end
        SHIFT: begin
          sa    <= sa_nx;
          sb    <= sb_nx;
          acc   <= acc_nx;
          count <= count + CW'(1);
          if (last_cyc) begin
            bus.res_valid <= 1'b1;
            bus.res_data  <= acc_nx;
            bus.res_id    <= gnt_id;
          end
        end
        DONE: begin
          if (done_ack) begin
            bus.res_valid <= 1'b0;
            last_grant    <= bus.res_id;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_arbiter.sv
// tb_dot_arbiter: directed scenarios for the dot_arbiter scheduler.
// Expected latencies follow DOT_ARBITER_EARLY_EXIT_EN when defined.
module tb_dot_arbiter;
  localparam int WIDTH = 6;
`ifdef DOT_ARBITER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  dot_arbiter_if #(.WIDTH(WIDTH)) bus ();

  dot_arbiter #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs;
    bus.req0_valid = 1'b0;
    bus.req0_a = '0;
    bus.req0_b = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a = '0;
    bus.req1_b = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_a = '1; bus.req0_b = '1;
    bus.req1_a = '1; bus.req1_b = '1;
    bus.res_ready = 1'b1;
    step;
    step;
    checks++;
    if (bus.req0_ready !== 1'b0) begin
      errors++; $display("FAIL rst_r0_ready got=%0b exp=0", bus.req0_ready);
    end
    checks++;
    if (bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL rst_r1_ready got=%0b exp=0", bus.req1_ready);
    end
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL rst_res_valid got=%0b exp=0", bus.res_valid);
    end
    checks++;
    if (bus.res_id !== 1'b0) begin
      errors++; $display("FAIL rst_res_id got=%0b exp=0", bus.res_id);
    end
    checks++;
    if (bus.res_data !== 3'd0) begin
      errors++; $display("FAIL rst_res_data got=%0d exp=0", bus.res_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got=%0b exp=0", busy);
    end
    clear_reqs();
    reset = 1'b0;
    step;
  endtask

  task automatic test_single;
    bus.req0_valid = 1'b1;
    bus.req0_a = 6'b111111;
    bus.req0_b = 6'b101010;
    bus.res_ready = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got=%0b%0b exp=10",
               bus.req0_ready, bus.req1_ready);
    end
    step;
    clear_reqs();
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (busy !== (k <= 7)) begin
        errors++; $display("FAIL single_busy c%0d got=%0b", k, busy);
      end
      checks++;
      if (bus.res_valid !== (k == 7)) begin
        errors++;
        $display("FAIL single_valid c%0d got=%0b", k, bus.res_valid);
      end
      if (k == 7) begin
        checks++;
        if (bus.res_data !== 3'd3 || bus.res_id !== 1'b0) begin
          errors++;
          $display("FAIL single_result got=%0d/%0b exp=3/0",
                   bus.res_data, bus.res_id);
        end
      end
      step;
    end
  endtask

  task automatic test_both_valid;
    int gid[4];
    int rid[4];
    int rdat[4];
    int ng = 0;
    int nr = 0;
    bit both = 1'b0;
    reset = 1'b1;
    step;
    reset = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 6'b111111; bus.req0_b = 6'b111111;
    bus.req1_valid = 1'b1;
    bus.req1_a = 6'b110011; bus.req1_b = 6'b010110;
    bus.res_ready = 1'b1;
    #1;
    for (int c = 0; c < 60 && nr < 2; c++) begin
      if (bus.req0_ready && bus.req1_ready) both = 1'b1;
      if (bus.req0_valid && bus.req0_ready && ng < 4) begin
        gid[ng] = 0; ng++;
      end
      if (bus.req1_valid && bus.req1_ready && ng < 4) begin
        gid[ng] = 1; ng++;
      end
      if (bus.res_valid && nr < 4) begin
        rid[nr] = int'(bus.res_id);
        rdat[nr] = int'(bus.res_data);
        nr++;
      end
      if (nr == 2) clear_reqs();
      else step;
    end
    checks++;
    if (nr !== 2) begin
      errors++; $display("FAIL both_count got=%0d exp=2", nr);
    end
    checks++;
    if (gid[0] !== 0 || gid[1] !== 1) begin
      errors++;
      $display("FAIL both_grants got=%0d,%0d exp=0,1", gid[0], gid[1]);
    end
    checks++;
    if (rid[0] !== 0 || rdat[0] !== 6) begin
      errors++;
      $display("FAIL both_res0 got=%0d/%0d exp=0/6", rid[0], rdat[0]);
    end
    checks++;
    if (rid[1] !== 1 || rdat[1] !== 2) begin
      errors++;
      $display("FAIL both_res1 got=%0d/%0d exp=1/2", rid[1], rdat[1]);
    end
    checks++;
    if (both !== 1'b0) begin
      errors++; $display("FAIL both_readies got=1 exp=0");
    end
    step;
  endtask

  task automatic test_round_robin;
    int gid[4];
    int rid[4];
    int rdat[4];
    int ng = 0;
    int nr = 0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 6'b010101; bus.req0_b = 6'b111111;
    bus.req1_valid = 1'b1;
    bus.req1_a = 6'b111100; bus.req1_b = 6'b001111;
    bus.res_ready = 1'b1;
    #1;
    for (int c = 0; c < 100 && nr < 4; c++) begin
      if (bus.req0_valid && bus.req0_ready && ng < 4) begin
        gid[ng] = 0; ng++;
      end
      if (bus.req1_valid && bus.req1_ready && ng < 4) begin
        gid[ng] = 1; ng++;
      end
      if (bus.res_valid && nr < 4) begin
        rid[nr] = int'(bus.res_id);
        rdat[nr] = int'(bus.res_data);
        nr++;
      end
      if (nr == 4) clear_reqs();
      else step;
    end
    checks++;
    if (nr !== 4) begin
      errors++; $display("FAIL rr_count got=%0d exp=4", nr);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gid[i] !== (i % 2) || rid[i] !== (i % 2)) begin
        errors++;
        $display("FAIL rr_id%0d got=%0d/%0d exp=%0d",
                 i, gid[i], rid[i], i % 2);
      end
      checks++;
      if (rdat[i] !== ((i % 2 == 0) ? 3 : 2)) begin
        errors++;
        $display("FAIL rr_data%0d got=%0d exp=%0d",
                 i, rdat[i], (i % 2 == 0) ? 3 : 2);
      end
    end
    step;
  endtask

  task automatic test_backpressure;
    int w;
    bus.req0_valid = 1'b1;
    bus.req0_a = 6'b111111; bus.req0_b = 6'b001111;
    bus.res_ready = 1'b0;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++; $display("FAIL bp_grant got=%0b exp=1", bus.req0_ready);
    end
    step;
    clear_reqs();
    w = 0;
    while (!bus.res_valid && w < 20) begin
      step; w++;
    end
    bus.req1_valid = 1'b1;
    bus.req1_a = 6'b111111; bus.req1_b = 6'b111111;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 3'd4 ||
          bus.res_id !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got=%0b/%0d/%0b exp=1/4/0", i,
                 bus.res_valid, bus.res_data, bus.res_id);
      end
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_readies%0d got=%0b%0b exp=00", i,
                 bus.req0_ready, bus.req1_ready);
      end
      step;
    end
    bus.res_ready = 1'b1;
    step;
    checks++;
    if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got=%0b/%0b exp=0/0", busy, bus.res_valid);
    end
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_next_grant got=%0b exp=1", bus.req1_ready);
    end
    step;
    clear_reqs();
    w = 0;
    while (!bus.res_valid && w < 20) begin
      step; w++;
    end
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b1 ||
        bus.res_data !== 3'd6) begin
      errors++;
      $display("FAIL bp_next_res got=%0b/%0b/%0d exp=1/1/6",
               bus.res_valid, bus.res_id, bus.res_data);
    end
    step;
  endtask

  task automatic test_reset_mid;
    int w;
    bit seen = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 6'b111111; bus.req0_b = 6'b111111;
    bus.res_ready = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++; $display("FAIL mid_grant got=%0b exp=1", bus.req0_ready);
    end
    step;
    clear_reqs();
    step;
    step;
    bus.req1_valid = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_id !== 1'b0 ||
        bus.res_data !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_outputs got=%0b/%0b/%0d/%0b exp=0/0/0/0",
               bus.res_valid, bus.res_id, bus.res_data, busy);
    end
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_readies got=%0b%0b exp=00",
               bus.req0_ready, bus.req1_ready);
    end
    #2;
    reset = 1'b0;
    bus.req1_valid = 1'b0;
    step;
    for (int i = 0; i < 12; i++) begin
      if (bus.res_valid) seen = 1'b1;
      step;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL mid_stale_valid got=1 exp=0");
    end
    bus.req1_valid = 1'b1;
    bus.req1_a = 6'b111111; bus.req1_b = 6'b010101;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++; $display("FAIL mid_new_grant got=%0b exp=1", bus.req1_ready);
    end
    step;
    clear_reqs();
    w = 0;
    while (!bus.res_valid && w < 20) begin
      step; w++;
    end
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b1 ||
        bus.res_data !== 3'd3) begin
      errors++;
      $display("FAIL mid_new_res got=%0b/%0b/%0d exp=1/1/3",
               bus.res_valid, bus.res_id, bus.res_data);
    end
    step;
  endtask

  task automatic test_latency;
    logic [5:0] va[4];
    logic [5:0] vb[4];
    int edat[4];
    int elat[4];
    int lat;
    va[0] = 6'b000011; vb[0] = 6'b111111; edat[0] = 2;
    elat[0] = EARLY ? 3 : 7;
    va[1] = 6'b000000; vb[1] = 6'b111111; edat[1] = 0;
    elat[1] = EARLY ? 2 : 7;
    va[2] = 6'b001000; vb[2] = 6'b111111; edat[2] = 1;
    elat[2] = EARLY ? 5 : 7;
    va[3] = 6'b111111; vb[3] = 6'b111111; edat[3] = 6;
    elat[3] = 7;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid = 1'b1;
      bus.req0_a = va[i];
      bus.req0_b = vb[i];
      step;
      clear_reqs();
      lat = 1;
      while (!bus.res_valid && lat < 20) begin
        step; lat++;
      end
      checks++;
      if (lat !== elat[i]) begin
        errors++;
        $display("FAIL lat%0d got=%0d exp=%0d", i, lat, elat[i]);
      end
      checks++;
      if (bus.res_data !== 3'(edat[i])) begin
        errors++;
        $display("FAIL lat_data%0d got=%0d exp=%0d",
                 i, bus.res_data, edat[i]);
      end
      step;
    end
  endtask

  initial begin
    clear_reqs();
    bus.res_ready = 1'b1;
    reset = 1'b1;
    #1;
    test_reset();
    test_single();
    test_both_valid();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
